data_sampler: RTL and testbench

//  UART RX oversampling data sampler. Takes 3 samples of rx_in around the middle of

---
 rtl/data_sampler.sv | 72 +++++++
 tb/tb_data_sampler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_sampler.sv
// UART RX oversampling data sampler: majority vote of three samples taken around mid-bit.
// Optional noise flag output enabled by defining DATA_SAMPLER_NOISE_FLAG_EN.
module data_sampler #(
  parameter int unsigned PWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWIDTH-1:0] prescale,
  input  logic [PWIDTH-1:0] edge_counter,
  input  logic              data_sampling_en,
  input  logic              rx_in,
  output logic              sampled_bit
`ifdef DATA_SAMPLER_NOISE_FLAG_EN
  ,
  output logic              noise_err
`endif
);

  logic [1:0]        ones;
  logic [1:0]        zeros;
  logic [PWIDTH-1:0] w_mid;
  logic              w_decode;
  logic              w_pt_first;
  logic              w_pt_mid;
  logic              w_pt_last;
  logic [2:0]        w_ones_total;
  logic [2:0]        w_zeros_total;

  always_comb begin
    w_mid         = prescale >> 1;
    w_decode      = (prescale >= PWIDTH'(4));
    w_pt_first    = w_decode && (edge_counter == (w_mid - PWIDTH'(1)));
    w_pt_mid      = w_decode && (edge_counter == w_mid);
    w_pt_last     = w_decode && (edge_counter == (w_mid + PWIDTH'(1)));
    w_ones_total  = {1'b0, ones}  + {2'b00, rx_in};
    w_zeros_total = {1'b0, zeros} + {2'b00, ~rx_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sampled_bit <= 1'b1;
      ones        <= '0;
      zeros       <= '0;
    end else if (!data_sampling_en) begin
      ones  <= '0;
      zeros <= '0;
    end else if (w_pt_first) begin
      ones  <= {1'b0, rx_in};
      zeros <= {1'b0, ~rx_in};
    end else if (w_pt_mid) begin
      // Saturate at 3 rather than wrap if edge_counter sequencing is broken.
      ones  <= (w_ones_total  > 3'd3) ? 2'd3 : w_ones_total[1:0];
      zeros <= (w_zeros_total > 3'd3) ? 2'd3 : w_zeros_total[1:0];
    end else if (w_pt_last) begin
      sampled_bit <= (w_ones_total >= 3'd2);
      ones        <= '0;
      zeros       <= '0;
    end
  end

`ifdef DATA_SAMPLER_NOISE_FLAG_EN
  // Samples agree only if all three landed on the same side of the vote.
  always_ff @(posedge clk) begin
    if (rst || !data_sampling_en) begin
      noise_err <= 1'b0;
    end else if (w_pt_last) begin
      noise_err <= !((w_ones_total >= 3'd3) || (w_zeros_total >= 3'd3));
    end
  end
`endif

endmodule

// File: tb/tb_data_sampler.sv
// Self-checking bench for data_sampler: sample-queue reference model feeding a scoreboard.
module tb_data_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prescale;
  logic [5:0] edge_counter;
  logic       data_sampling_en;
  logic       rx_in;
  logic       sampled_bit;
`ifdef DATA_SAMPLER_NOISE_FLAG_EN
  logic       noise_err;
`endif

  always #5 clk = ~clk;

  data_sampler #(.PWIDTH(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .prescale         (prescale),
    .edge_counter     (edge_counter),
    .data_sampling_en (data_sampling_en),
    .rx_in            (rx_in),
    .sampled_bit      (sampled_bit)
`ifdef DATA_SAMPLER_NOISE_FLAG_EN
    ,
    .noise_err        (noise_err)
`endif
  );

  typedef struct {
    logic       b;
    logic [1:0] o;
    logic [1:0] z;
    logic       n;
  } exp_t;

  exp_t sb_q[$];
  logic m_samp[$];
  logic m_bit;
  logic m_noise;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int count_val(input logic v);
    int c = 0;
    foreach (m_samp[i]) if (m_samp[i] == v) c++;
    return c;
  endfunction

  function automatic logic [1:0] sat3(input int c);
    return (c > 3) ? 2'd3 : c[1:0];
  endfunction

  // Reference: keep the raw samples of the current vote; counters are their tallies.
  task automatic model_update(input logic r, input logic en, input int ps, input int ec,
                              input logic rx);
    int mid;
    int c1;
    int c0;
    if (r) begin
      m_bit = 1'b1; m_noise = 1'b0; m_samp.delete();
    end else if (!en) begin
      m_noise = 1'b0; m_samp.delete();
    end else if (ps >= 4) begin
      mid = ps / 2;
      if (ec == mid - 1) begin
        m_samp.delete(); m_samp.push_back(rx);
      end else if (ec == mid) begin
        m_samp.push_back(rx);
      end else if (ec == mid + 1) begin
        m_samp.push_back(rx);
        c1 = count_val(1'b1);
        c0 = count_val(1'b0);
        m_bit   = (c1 >= 2);
        m_noise = !((c1 >= 3) || (c0 >= 3));
        m_samp.delete();
      end
    end
  endtask

  task automatic step(input logic r, input logic en, input int ps, input int ec,
                      input logic rx, input string tag);
    exp_t e;
    rst = r; data_sampling_en = en; prescale = ps[5:0]; edge_counter = ec[5:0]; rx_in = rx;
    model_update(r, en, ps, ec, rx);
    e.b = m_bit;
    e.o = sat3(count_val(1'b1));
    e.z = sat3(count_val(1'b0));
    e.n = m_noise;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val({tag, ".bit"},   {7'd0, sampled_bit}, {7'd0, e.b});
    check_val({tag, ".ones"},  {6'd0, dut.ones},    {6'd0, e.o});
    check_val({tag, ".zeros"}, {6'd0, dut.zeros},   {6'd0, e.z});
`ifdef DATA_SAMPLER_NOISE_FLAG_EN
    check_val({tag, ".noise"}, {7'd0, noise_err},   {7'd0, e.n});
`endif
  endtask

  task automatic run_bit(input int ps, input logic rx, input string tag);
    for (int ec = 0; ec < ps; ec++) step(1'b0, 1'b1, ps, ec, rx, tag);
  endtask

  initial begin
    m_bit = 1'b1; m_noise = 1'b0;
    rst = 1'b1; data_sampling_en = 1'b1; prescale = 6'd16; edge_counter = 6'd7; rx_in = 1'b0;
    #1;

    // Reset wins over an active sample point.
    step(1'b1, 1'b1, 16, 7, 1'b0, "rst0");
    step(1'b1, 1'b1, 16, 8, 1'b0, "rst1");
    check_val("rst_bit_const", {7'd0, sampled_bit}, 8'd1);

    // Toggling line: 0@7, 1@8, 0@9 -> 0.
    for (int ec = 1; ec <= 10; ec++) step(1'b0, 1'b1, 16, ec, (ec % 2 == 0), "toggle");
    check_val("toggle_bit_const", {7'd0, sampled_bit}, 8'd0);

    // 1,1,0 -> 1 with noise.
    for (int ec = 0; ec < 16; ec++) step(1'b0, 1'b1, 16, ec, (ec != 9), "noisy1");
    check_val("noisy1_bit_const", {7'd0, sampled_bit}, 8'd1);

    // prescale 8: clean zero at 3,4,5.
    run_bit(8, 1'b0, "ps8_zero");
    check_val("ps8_bit_const", {7'd0, sampled_bit}, 8'd0);
    run_bit(8, 1'b1, "ps8_one");

    // Disabled sweep holds the last bit.
    for (int ec = 0; ec < 16; ec++) step(1'b0, 1'b0, 16, ec, 1'b0, "en_off");
    check_val("en_off_hold_const", {7'd0, sampled_bit}, 8'd1);

    // Enable drops after edge 8: partial vote discarded, next bit restarts.
    for (int ec = 0; ec <= 8; ec++) step(1'b0, 1'b1, 16, ec, 1'b0, "drop_a");
    for (int ec = 9; ec < 16; ec++) step(1'b0, 1'b0, 16, ec, 1'b0, "drop_b");
    check_val("drop_hold_const", {7'd0, sampled_bit}, 8'd1);
    run_bit(16, 1'b0, "drop_next");

    // Skipped sample points: tie resolves to 0, two ones give 1.
    run_bit(16, 1'b1, "pre_skip");
    step(1'b0, 1'b1, 16, 7, 1'b1, "skip_mid_a");
    step(1'b0, 1'b1, 16, 9, 1'b0, "skip_mid_b");
    step(1'b0, 1'b1, 16, 8, 1'b1, "skip_first_a");
    step(1'b0, 1'b1, 16, 9, 1'b1, "skip_first_b");

    // prescale below 4: nothing decoded.
    for (int ps = 0; ps < 4; ps++)
      for (int ec = 0; ec < 4; ec++) step(1'b0, 1'b1, ps, ec, ec[0], "small_ps");

    // Largest prescale: mid+1 = 32.
    run_bit(63, 1'b0, "ps63_zero");
    run_bit(63, 1'b1, "ps63_one");

    // Reset mid-vote.
    step(1'b0, 1'b1, 16, 7, 1'b0, "rst_mid_a");
    step(1'b0, 1'b1, 16, 8, 1'b0, "rst_mid_b");
    step(1'b1, 1'b1, 16, 9, 1'b0, "rst_mid_c");

    // Random bits with random per-cycle line noise.
    for (int n = 0; n < 40; n++) begin
      int ps;
      ps = $urandom_range(40, 4);
      for (int ec = 0; ec < ps; ec++)
        step(1'b0, 1'b1, ps, ec, 1'($urandom_range(1, 0)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
